// File: rtl/cry_rgb_scaler.sv
// ---------------------------------------------------------------------------
// cry_rgb_scaler
//
// Pixel-path stage that sits directly after the three CRY colour ROMs
// (red, green, blue; 256x8; one registered read per sys_clk).
//
// Each accepted 16-bit CRY pixel drives the shared ROM address with its
// colour byte. One cycle later the ROMs return R, G and B. Each byte is then
// scaled by the pixel's Y intensity: (rom * Y) >> 8, truncated. The 24-bit
// result is pushed into a small FIFO. The FIFO feeds the line-buffer writer
// through a valid/ready handshake.
//
// Issue is credit-gated. A pixel is only accepted when the FIFO plus the
// S1 slot still have room for it. Because of this, the fixed-latency ROM
// read never needs to be stalled, and the FIFO is never full when S1 writes.
//
// Ports:
//   sys_clk    in   1   sole clock (rising edge), also clocks the ROMs
//   reset      in   1   asynchronous, active-high
//   in_pix     in  16   CRY pixel: [15:12] cyan, [11:8] red, [7:0] Y
//   in_valid   in   1   in_pix is valid
//   in_ready   out  1   stage accepts in_pix this cycle (registers only)
//   rom_addr   out  8   address to all three ROMs, = in_pix[15:8]
//   rom_r/g/b  in   8   ROM data, valid one cycle after the address
//   out_rgb    out 24   FIFO head {R, G, B}
//   out_valid  out  1   FIFO head is valid
//   out_ready  in   1   sink takes the head this cycle
// ---------------------------------------------------------------------------
module cry_rgb_scaler #(
  parameter int DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [15:0] in_pix,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_r,
  input  logic [7:0]  rom_g,
  input  logic [7:0]  rom_b,
  output logic [23:0] out_rgb,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // pointer width
  localparam int CW = AW + 1;                           // count width, 0..DEPTH
  localparam int NCH = 3;                               // R, G, B

  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic            s1_v_reg;
  logic [7:0]      s1_y_reg;

  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   rd_ptr_next;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;

  logic [23:0]     fifo_mem [DEPTH];

  logic [7:0]      rom_byte [NCH];
  logic [7:0]      scaled   [NCH];
  logic [23:0]     s1_rgb;

  logic [CW:0]     credit_used;
  logic            accept;
  logic            push;
  logic            pop;

  // -------------------------------------------------------------------------
  // ROM address
  // -------------------------------------------------------------------------
  // The address always follows the incoming colour byte, even when nothing
  // is accepted. A read that was not accepted is simply ignored, because
  // s1_v_reg stays low.
  assign rom_addr = in_pix[15:8];

  // -------------------------------------------------------------------------
  // Credit and handshake
  // -------------------------------------------------------------------------
  // Occupancy counts the FIFO entries plus the pixel in S1. A pop in the same
  // cycle is not credited back. This keeps in_ready a function of registers
  // only, at the cost of one bubble when resuming.
  assign credit_used = {1'b0, count_reg} + {{CW{1'b0}}, s1_v_reg};
  assign in_ready    = (credit_used < CREDIT_MAX);
  assign accept      = in_valid && in_ready;

  assign out_valid   = (count_reg != '0);
  assign pop         = out_valid && out_ready;
  assign push        = s1_v_reg;

  // -------------------------------------------------------------------------
  // S1: Y capture (the ROMs hold the colour side of the pipeline)
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      s1_v_reg <= 1'b0;
      s1_y_reg <= 8'd0;
    end else begin
      s1_v_reg <= accept;
      if (accept) begin
        s1_y_reg <= in_pix[7:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // S1: per-channel intensity scaling
  // -------------------------------------------------------------------------
  // Channel 0 is red and lands in the top byte of the RGB word.
  assign rom_byte[0] = rom_r;
  assign rom_byte[1] = rom_g;
  assign rom_byte[2] = rom_b;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      logic [15:0] product;
      // Full 16-bit product. The upper byte is the truncated result.
      assign product    = {8'd0, rom_byte[gi]} * {8'd0, s1_y_reg};
      assign scaled[gi] = product[15:8];
      assign s1_rgb[23 - 8*gi -: 8] = scaled[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;  // idle, or push and pop together
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage
  // -------------------------------------------------------------------------
  // Storage is left uninitialised by reset. out_valid qualifies the head, so
  // stale contents are never observed as data.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= s1_rgb;
    end
  end

  assign out_rgb = fifo_mem[rd_ptr_reg];

endmodule

// File: tb/tb_cry_rgb_scaler.sv
// ---------------------------------------------------------------------------
// tb_cry_rgb_scaler
//
// Self-checking bench for cry_rgb_scaler (DEPTH = 4).
//
// The ROMs are modelled as registered table lookups.
//
// The reference model is expressed as a transaction queue:
//   - every accepted pixel becomes an expected RGB word;
//   - a word becomes visible two cycles after its accept;
//   - in_ready is high while fewer than DEPTH pixels are in flight
//     (accepted but not yet popped).
//
// A compare process on the falling edge checks in_ready, out_valid,
// rom_addr and out_rgb against this model on every cycle.
// ---------------------------------------------------------------------------
module tb_cry_rgb_scaler;

  localparam int DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] in_pix  = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_r = 8'h00;
  logic [7:0]  rom_g = 8'h00;
  logic [7:0]  rom_b = 8'h00;
  logic [23:0] out_rgb;
  logic        out_valid;
  logic        out_ready = 1'b1;

  cry_rgb_scaler #(.DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .in_pix    (in_pix),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rom_addr  (rom_addr),
    .rom_r     (rom_r),
    .rom_g     (rom_g),
    .rom_b     (rom_b),
    .out_rgb   (out_rgb),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 sys_clk = ~sys_clk;

  // -------------------------------------------------------------------------
  // ROM models
  // -------------------------------------------------------------------------
  logic [7:0] tab_r [256];
  logic [7:0] tab_g [256];
  logic [7:0] tab_b [256];

  always @(posedge sys_clk) begin
    rom_r <= tab_r[rom_addr];
    rom_g <= tab_g[rom_addr];
    rom_b <= tab_b[rom_addr];
  end

  // -------------------------------------------------------------------------
  // Checking infrastructure
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_rgb(input logic [15:0] p);
    int y;
    int r;
    int g;
    int b;
    y = int'(p[7:0]);
    r = (int'(tab_r[p[15:8]]) * y) / 256;
    g = (int'(tab_g[p[15:8]]) * y) / 256;
    b = (int'(tab_b[p[15:8]]) * y) / 256;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  // -------------------------------------------------------------------------
  // Transaction-level model and compare process
  // -------------------------------------------------------------------------
  logic [23:0] exp_q [$];
  int          acc_cyc_q [$];
  int          cyc = 0;
  int          acc_count = 0;
  int          pop_count = 0;
  bit          stream_phase = 0;
  int          ready_low_cnt = 0;
  bit          bp_arm = 0;
  int          first_pop_cyc = -1;
  int          first_acc_cyc = -1;

  always @(negedge sys_clk) begin
    bit exp_ready;
    bit exp_ovalid;
    if (reset) begin
      exp_q.delete();
      acc_cyc_q.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end else begin
      exp_ready  = (exp_q.size() < DEPTH);
      exp_ovalid = (acc_cyc_q.size() > 0) && (acc_cyc_q[0] <= cyc - 2);
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("out_valid", 32'(out_valid), 32'(exp_ovalid));
      chk("rom_addr", 32'(rom_addr), 32'(in_pix[15:8]));
      if (exp_ovalid) begin
        chk("out_rgb", 32'(out_rgb), 32'(exp_q[0]));
      end
      if (stream_phase && !in_ready) begin
        ready_low_cnt++;
      end
      if (exp_ovalid && out_ready) begin
        void'(exp_q.pop_front());
        void'(acc_cyc_q.pop_front());
        pop_count++;
        if (bp_arm && first_pop_cyc < 0) begin
          first_pop_cyc = cyc;
        end
      end
      if (in_valid && exp_ready) begin
        exp_q.push_back(model_rgb(in_pix));
        acc_cyc_q.push_back(cyc);
        acc_count++;
        if (bp_arm && first_pop_cyc >= 0 && first_acc_cyc < 0) begin
          first_acc_cyc = cyc;
        end
      end
    end
    cyc++;
  end

  // -------------------------------------------------------------------------
  // Directed single-pixel transfer with literal expectations
  // -------------------------------------------------------------------------
  task automatic send_check(input string nm, input logic [15:0] p,
                            input logic [23:0] exp_rgb);
    @(posedge sys_clk); #1;
    in_pix   = p;
    in_valid = 1'b1;
    #1;
    chk({nm, "_addr"}, 32'(rom_addr), 32'(p[15:8]));
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge sys_clk); #1;            // accept happened on this edge
    in_valid = 1'b0;
    @(negedge sys_clk);                // N+1
    chk({nm, "_ov_n1"}, 32'(out_valid), 32'd0);
    @(negedge sys_clk);                // N+2
    chk({nm, "_ov_n2"}, 32'(out_valid), 32'd1);
    chk({nm, "_rgb"}, 32'(out_rgb), 32'(exp_rgb));
    $display("txn %s: pix=%h rgb=%h", nm, p, out_rgb);
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int a0;
    logic [15:0] p;

    // CRY-style tables: smooth ramps over the cyan/red nibbles.
    for (int i = 0; i < 256; i++) begin
      tab_r[i] = 8'((i & 15) * 17);
      tab_g[i] = 8'(255 - ((i >> 4) * 17));
      tab_b[i] = 8'(((i >> 4) * 9) + ((i & 15) * 6));
    end
    tab_r[8'h80] = 8'hFF; tab_g[8'h80] = 8'h00; tab_b[8'h80] = 8'h00;
    tab_r[8'h12] = 8'h40; tab_g[8'h12] = 8'h80; tab_b[8'h12] = 8'hFF;

    // Reset state
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge sys_clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge sys_clk);

    // Literal expectations: 0xFF*0xFF>>8 = 0xFE; Y=0 -> black;
    // 0x40/0x80/0xFF scaled by 0x80 -> 0x20/0x40/0x7F.
    send_check("single", 16'h80FF, 24'hFE0000);
    send_check("zero_y", 16'h5A00, 24'h000000);
    send_check("half_y", 16'h1280, 24'h20407F);
    repeat (4) @(posedge sys_clk);

    // Streaming: 64 back-to-back pixels, sink always ready
    a0 = acc_count;
    stream_phase = 1;
    for (int i = 0; i < 64; i++) begin
      @(posedge sys_clk); #1;
      in_pix   = 16'($urandom);
      in_valid = 1'b1;
    end
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    stream_phase = 0;
    chk("stream_accepts", 32'(acc_count - a0), 32'd64);
    chk("stream_ready_low", 32'(ready_low_cnt), 32'd0);
    $display("txn stream: accepted=%0d ready_low=%0d", acc_count - a0, ready_low_cnt);
    repeat (4) @(posedge sys_clk);

    // Backpressure: sink stalled, continuous offers
    a0 = acc_count;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk); #1;
      in_pix   = 16'($urandom);
      in_valid = 1'b1;
    end
    chk("bp_accepts", 32'(acc_count - a0), 32'(DEPTH));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    $display("txn backpressure: held=%0d in_ready=%0b", acc_count - a0, in_ready);

    // Release: drain and restart. Streaming on here keeps count around 2..3,
    // so push and pop happen together across many pointer wraps.
    bp_arm = 1;
    out_ready = 1'b1;
    a0 = pop_count;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      @(posedge sys_clk); #1;
      in_pix = 16'($urandom);
    end
    in_valid = 1'b0;
    bp_arm = 0;
    chk("bp_restart_gap", 32'(first_acc_cyc - first_pop_cyc), 32'd1);
    chk("wrap_pops_ge", 32'(pop_count - a0 >= 3 * DEPTH), 32'd1);
    $display("txn resume: first_pop=%0d first_acc=%0d pops=%0d",
             first_pop_cyc, first_acc_cyc, pop_count - a0);
    repeat (6) @(posedge sys_clk);

    // Random traffic on both handshakes
    for (int i = 0; i < 300; i++) begin
      @(posedge sys_clk); #1;
      in_pix    = 16'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge sys_clk);
    chk("random_drained", 32'(exp_q.size()), 32'd0);
    $display("txn random: accepted=%0d popped=%0d", acc_count, pop_count);

    // Reset mid-operation with count=3 and S1 occupied
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge sys_clk); #1;
      p        = 16'($urandom);
      in_pix   = p;
      in_valid = 1'b1;
    end
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    $display("txn async_reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    @(posedge sys_clk); #2;
    reset = 1'b0;
    out_ready = 1'b1;
    send_check("post_rst", 16'h1280, 24'h20407F);
    repeat (4) @(posedge sys_clk);
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cry_rgb_scaler.md
# cry_rgb_scaler

Pixel-path stage directly downstream of the three CRY colour ROMs (red, green, blue, 256x8, one registered read per `sys_clk`). It accepts 16-bit CRY pixels, drives the shared 8-bit ROM address, and multiplies each returned ROM byte by the pixel's Y intensity. It buffers the resulting 24-bit RGB words in a small FIFO and presents them to the line-buffer writer through a valid/ready handshake. Issue is credit-gated, so the fixed-latency ROMs never need to be stalled.

## Interface
- `DEPTH`, 4, output FIFO entries (power of two, ≥2); also the total credit limit.
- `sys_clk` in 1: sole clock, rising edge; also clocks the three ROMs.
- `reset` in 1: asynchronous, active-high.
- `in_pix` in 16: CRY pixel; [15:12] cyan, [11:8] red, [7:0] Y.
- `in_valid` in 1: `in_pix` is valid.
- `in_ready` out 1: stage accepts `in_pix` this cycle.
- `rom_addr` out 8: address to all three ROMs; equals `in_pix[15:8]`, combinational.
- `rom_r`, `rom_g`, `rom_b` in 8 each: ROM outputs, valid one cycle after the address.
- `out_rgb` out 24: {R[23:16], G[15:8], B[7:0]}.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: sink takes the head this cycle.

## Operation
- Accept: `in_valid && in_ready` in cycle N. `rom_addr` is sampled by the ROMs at the end of N. `in_pix[7:0]` is captured into the S1 Y register and `s1_v` is set.
- S1 (cycle N+1): ROM data is valid. Each channel computes `(rom_x * Y) >> 8` as an 8-bit result (16-bit product, bits [15:8]), with no rounding. The result is written to the FIFO at the end of N+1 when `s1_v` is set.
- `s1_v` clears in any cycle without an accept.
- Credit: `in_ready = (count + s1_v) < DEPTH`. `count` is the FIFO occupancy. A pop in the same cycle is deliberately ignored, to keep the path short. The FIFO can therefore never be full when S1 writes.
- FIFO: `DEPTH` entries, wrapping read/write pointers, `count` 0..DEPTH.
  - Push-only: count+1. Pop-only: count−1. Push and pop together: count unchanged, both pointers advance.
  - `out_valid = (count != 0)`. `out_rgb` = head entry.
  - Pop = `out_valid && out_ready`. `out_ready` while empty has no effect.
- `rom_addr` always follows `in_pix[15:8]`, even when no accept happens. The ROM read is harmless, because `s1_v` qualifies it.
- Reset (asynchronous, any time, including mid-burst): `s1_v`=0, pointers=0, `count`=0, S1 Y=0. FIFO storage is not cleared.
- Outputs during reset: `out_valid`=0, `in_ready`=1, `out_rgb`=entry 0 contents (don't-care).
- Any pixel in flight when reset asserts is dropped.

## Timing
- Latency: accept in N gives `out_valid` in N+2 when the FIFO was empty.
- Throughput: with `out_ready` held at 1, one pixel per cycle indefinitely. Steady state is `count`≤1 and `s1_v`=1.
- Backpressure: after `out_ready` drops, at most `DEPTH` pixels are held (FIFO plus S1). `in_ready` falls in the cycle where `count + s1_v` reaches `DEPTH`.
- Resume: `in_ready` returns the cycle after a pop reduces `count + s1_v` below `DEPTH`. This costs one bubble versus a pop-aware scheme, which is acceptable.
- `in_ready` and `out_valid` depend on registers only. There is no combinational path from `out_ready` or `in_valid` to any output except through `rom_addr = in_pix[15:8]`.

## Test plan
- Single pixel: `in_pix`=16'h80FF, ROMs return R=FF, G=00, B=00. Required: `rom_addr`=8'h80; `out_valid` rises at N+2; `out_rgb`=24'hFE0000.
- Zero intensity: `in_pix`=16'h5A00 with any ROM data. Required: `out_rgb`=24'h000000.
- Streaming: 64 consecutive pixels with `out_ready`=1 and ROM models loaded with the CRY tables. Required:
  - `in_ready` never drops;
  - outputs arrive in order, one per cycle from N+2;
  - each value matches the reference model `(rom*Y)>>8`.
- Backpressure, `DEPTH`=4: hold `out_ready`=0 and present continuous `in_valid`. Required:
  - exactly 4 accepts, then `in_ready`=0;
  - raising `out_ready` drains 4 correct words in order;
  - accepts restart one cycle after the first pop.
- Simultaneous push/pop with `count`=2: `count` is unchanged, and the pointers wrap correctly across 3×`DEPTH` transfers.
- Reset mid-operation: assert `reset` with `count`=3 and `s1_v`=1. Required:
  - `out_valid`=0 and `in_ready`=1 immediately (asynchronous);
  - after release, the first new pixel is output at N+2 with no stale data.
